// File: rtl/speed_lim_loader_pkg.sv
// Shared constants and state encodings for the speed-limit map loader.
package speed_lim_loader_pkg;

  localparam int unsigned DEF_CLKS_PER_BIT = 868;
  localparam logic [7:0]  SYNC_BYTE        = 8'hA5;

  // Frame-level loader states
  typedef enum logic [1:0] {
    LD_SYNC = 2'd0,
    LD_ADDR = 2'd1,
    LD_DATA = 2'd2,
    LD_CSUM = 2'd3
  } ld_state_e;

  // UART receiver states
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/speed_lim_loader_uart_rx.sv
// 8N1 UART receiver: 2-FF synchroniser, mid-bit sampling, false-start rejection.
module uart_rx
  import speed_lim_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       stop_err
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [1:0]       sync_q;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             armed_q, armed_d;
  logic             byte_valid_q, byte_valid_d;
  logic [7:0]       byte_data_q, byte_data_d;
  logic             stop_err_q, stop_err_d;
  logic             rx_s;

  assign rx_s       = sync_q[1];
  assign byte_valid = byte_valid_q;
  assign byte_data  = byte_data_q;
  assign stop_err   = stop_err_q;

  // Synchroniser, reset to the idle (high) line level
  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], rx};
  end

  // Receiver state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RX_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      armed_q      <= 1'b0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= '0;
      stop_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      armed_q      <= armed_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q  <= byte_data_d;
      stop_err_q   <= stop_err_d;
    end
  end

  // Bit timing and sampling; armed_q requires a high line before each start edge
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 1'b1;
    bit_d        = bit_q;
    shift_d      = shift_q;
    armed_d      = armed_q;
    byte_valid_d = 1'b0;
    byte_data_d  = byte_data_q;
    stop_err_d   = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (rx_s) armed_d = 1'b1;
        if (armed_q && !rx_s) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          bit_d = '0;
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          armed_d = 1'b0;
          state_d = RX_IDLE;
          if (rx_s) begin
            byte_valid_d = 1'b1;
            byte_data_d  = shift_q;
          end else begin
            stop_err_d = 1'b1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/speed_lim_loader.sv
// Speed-limit map RAM writer: validates A5/ADDR/DATA/CSUM frames from a UART and commits them.
module speed_lim_loader
  import speed_lim_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT   = DEF_CLKS_PER_BIT,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned ADDR_W         = 4,
  parameter int unsigned DATA_W         = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              busy,
  output logic              frame_err,
  output logic [7:0]        wr_count
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        stop_err;

  ld_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_din_q, mem_din_d;
  logic              busy_q, busy_d;
  logic              frame_err_q, frame_err_d;
  logic [7:0]        wr_count_q, wr_count_d;
  logic              abort;
  logic [7:0]        csum_exp;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .stop_err   (stop_err)
  );

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;
  assign wr_count  = wr_count_q;
  assign csum_exp  = SYNC_BYTE ^ 8'(addr_q) ^ 8'(data_q);

  // Frame FSM and write-port registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LD_SYNC;
      addr_q      <= '0;
      data_q      <= '0;
      tmo_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      wr_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      tmo_q       <= tmo_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
      wr_count_q  <= wr_count_d;
    end
  end

  // Byte validation, commit and abort (field error, stop error, inter-byte timeout)
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    tmo_d       = (state_q == LD_SYNC || byte_valid) ? '0 : tmo_q + 1'b1;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    frame_err_d = 1'b0;
    wr_count_d  = wr_count_q;
    abort       = 1'b0;
    if (byte_valid) begin
      case (state_q)
        LD_SYNC: if (byte_data == SYNC_BYTE) state_d = LD_ADDR;
        LD_ADDR: begin
          if (byte_data[7:ADDR_W] != '0) abort = 1'b1;
          else begin
            addr_d  = byte_data[ADDR_W-1:0];
            state_d = LD_DATA;
          end
        end
        LD_DATA: begin
          if (byte_data[7:DATA_W] != '0) abort = 1'b1;
          else begin
            data_d  = byte_data[DATA_W-1:0];
            state_d = LD_CSUM;
          end
        end
        LD_CSUM: begin
          if (byte_data == csum_exp) begin
            mem_we_d   = 1'b1;
            mem_addr_d = addr_q;
            mem_din_d  = data_q;
            wr_count_d = wr_count_q + 1'b1;
            state_d    = LD_SYNC;
          end else begin
            abort = 1'b1;
          end
        end
        default: state_d = LD_SYNC;
      endcase
    end else if (state_q != LD_SYNC && (stop_err || tmo_q == TMO_LAST)) begin
      abort = 1'b1;
    end
    if (abort) begin
      frame_err_d = 1'b1;
      state_d     = LD_SYNC;
    end
    busy_d = (state_d != LD_SYNC);
  end

endmodule

// File: tb/tb_speed_lim_loader.sv
// Directed bench for speed_lim_loader with a write scoreboard and a behavioural 16x7 RAM.
module tb_speed_lim_loader;

  localparam int unsigned CPB = 16;
  localparam int unsigned TMO = 2000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [6:0] mem_din;
  logic       busy;
  logic       frame_err;
  logic [7:0] wr_count;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int ferr_cnt = 0;
  int we0, f0;
  logic [6:0]  ram [16];
  logic [10:0] exp_q [$];
  logic [10:0] exp_w;

  speed_lim_loader #(
    .CLKS_PER_BIT   (CPB),
    .TIMEOUT_CYCLES (TMO),
    .ADDR_W         (4),
    .DATA_W         (7)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .busy      (busy),
    .frame_err (frame_err),
    .wr_count  (wr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // RAM model, scoreboard pop and pulse counting, sampled away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we) begin
        we_cnt++;
        ram[mem_addr] = mem_din;
        check("we_expected", 32'(exp_q.size() != 0), 32'd1);
        check("we_no_ferr", 32'(frame_err), 32'd0);
        if (exp_q.size() != 0) begin
          exp_w = exp_q.pop_front();
          check("write_addr_din", 32'({mem_addr, mem_din}), 32'(exp_w));
        end
      end
      if (frame_err) ferr_cnt++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(CPB);
    end
    rx = stop_bit;
    idle(CPB);
    rx = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
    send_byte(8'hA5, 1'b1);
    send_byte(a, 1'b1);
    send_byte(d, 1'b1);
    send_byte(c, 1'b1);
    idle(30);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = 7'h00;
    rst = 1'b1;
    rx  = 1'b1;
    idle(3);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_outputs", 32'({mem_addr, mem_din, busy, frame_err, wr_count}), 32'd0);
    rst = 1'b0;
    idle(20);

    // 1: valid frame
    we0 = we_cnt; f0 = ferr_cnt;
    exp_q.push_back({4'd3, 7'h32});
    send_frame(8'h03, 8'h32, 8'h94);
    check("t1_we_pulses", 32'(we_cnt - we0), 32'd1);
    check("t1_wr_count", 32'(wr_count), 32'd1);
    check("t1_no_ferr", 32'(ferr_cnt - f0), 32'd0);
    check("t1_ram3", 32'(ram[3]), 32'h32);
    check("t1_busy", 32'(busy), 32'd0);

    // 2: bad checksum, error only after the 4th byte
    we0 = we_cnt; f0 = ferr_cnt;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h32, 1'b1);
    check("t2_busy_mid", 32'(busy), 32'd1);
    check("t2_ferr_before_csum", 32'(ferr_cnt - f0), 32'd0);
    send_byte(8'h95, 1'b1);
    idle(30);
    check("t2_ferr", 32'(ferr_cnt - f0), 32'd1);
    check("t2_no_we", 32'(we_cnt - we0), 32'd0);
    check("t2_ram3", 32'(ram[3]), 32'h32);
    check("t2_wr_count", 32'(wr_count), 32'd1);

    // 3: address out of range, then a good frame to the top address (csum A5^0F^7F = D5)
    f0 = ferr_cnt;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h13, 1'b1);
    idle(10);
    check("t3_ferr_addr", 32'(ferr_cnt - f0), 32'd1);
    check("t3_busy", 32'(busy), 32'd0);
    exp_q.push_back({4'd15, 7'h7F});
    send_frame(8'h0F, 8'h7F, 8'hD5);
    check("t3_ram15", 32'(ram[15]), 32'h7F);
    check("t3_wr_count", 32'(wr_count), 32'd2);

    // 4: stop bit low mid-frame, then recovery
    f0 = ferr_cnt;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h05, 1'b0);
    idle(30);
    check("t4_ferr_stop", 32'(ferr_cnt - f0), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    exp_q.push_back({4'd5, 7'h28});
    send_frame(8'h05, 8'h28, 8'h88);
    check("t4_ram5", 32'(ram[5]), 32'h28);
    check("t4_wr_count", 32'(wr_count), 32'd3);

    // 5: inter-byte timeout, then garbage ignored in SYNC
    f0 = ferr_cnt; we0 = we_cnt;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h03, 1'b1);
    idle(1900);
    check("t5_busy_before_tmo", 32'(busy), 32'd1);
    check("t5_no_ferr_before_tmo", 32'(ferr_cnt - f0), 32'd0);
    idle(200);
    check("t5_ferr_tmo", 32'(ferr_cnt - f0), 32'd1);
    check("t5_busy_after_tmo", 32'(busy), 32'd0);
    f0 = ferr_cnt;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    idle(30);
    check("t5_garbage_no_ferr", 32'(ferr_cnt - f0), 32'd0);
    check("t5_garbage_no_we", 32'(we_cnt - we0), 32'd0);

    // 6a: short low glitch inside a frame must not become a byte (csum A5^06^3C = 9F)
    f0 = ferr_cnt;
    exp_q.push_back({4'd6, 7'h3C});
    send_byte(8'hA5, 1'b1);
    rx = 1'b0;
    idle(6);
    rx = 1'b1;
    idle(40);
    send_byte(8'h06, 1'b1);
    send_byte(8'h3C, 1'b1);
    send_byte(8'h9F, 1'b1);
    idle(30);
    check("t6_glitch_no_ferr", 32'(ferr_cnt - f0), 32'd0);
    check("t6_ram6", 32'(ram[6]), 32'h3C);
    check("t6_wr_count", 32'(wr_count), 32'd4);

    // 6b: reset in the middle of the DATA byte
    send_byte(8'hA5, 1'b1);
    send_byte(8'h07, 1'b1);
    rx = 1'b0;
    idle(CPB);
    rx = 1'b1;
    idle(CPB);
    rx = 1'b0;
    idle(2 * CPB);
    rst = 1'b1;
    idle(1);
    check("t6_rst_outputs", 32'({mem_we, mem_addr, mem_din, busy, frame_err, wr_count}), 32'd0);
    rst = 1'b0;
    rx  = 1'b1;
    idle(30);
    exp_q.push_back({4'd7, 7'h11});
    send_frame(8'h07, 8'h11, 8'hB3);
    check("t6_post_rst_ram7", 32'(ram[7]), 32'h11);
    check("t6_post_rst_wr_count", 32'(wr_count), 32'd1);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
